// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: steers store lanes, extends load data and drives a
// word-addressed req/gnt/rvalid data bus, stalling the pipeline until the access completes.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [3:0]  BE,
    input  logic [2:0]  funct3,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        done,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        D_REQ,
    output logic        D_WE,
    output logic [31:0] D_ADDR,
    output logic [3:0]  D_BE,
    output logic [31:0] D_WDATA,
    input  logic        D_GNT,
    input  logic        D_RVALID,
    input  logic [31:0] D_RDATA
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [2:0]  funct3_r;
    logic [1:0]  off_r;
    logic        acc_s;
    logic        illegal_s;
    logic        tmo_s;

    function automatic logic access_illegal(input logic [3:0] be, input logic [1:0] off);
        logic bad;
        case (be)
            4'b0001: bad = 1'b0;
            4'b0011: bad = off[0];
            4'b1111: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [2:0] kind);
        logic [31:0] s;
        logic [31:0] r;
        s = word >> {off, 3'b000};
        case (kind)
            3'b000:  r = {{24{s[7]}}, s[7:0]};
            3'b001:  r = {{16{s[15]}}, s[15:0]};
            3'b010:  r = s;
            3'b100:  r = {24'd0, s[7:0]};
            3'b101:  r = {16'd0, s[15:0]};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Request decode and combinational pipeline controls
    always_comb begin
        acc_s     = MemRead | MemWrite;
        illegal_s = access_illegal(BE, ADDR[1:0]);
        tmo_s     = (cnt_r == CNT_LAST);
        if (state_r == IDLE) begin
            misalign = acc_s & illegal_s;
            stall    = acc_s & ~illegal_s;
        end else begin
            misalign = 1'b0;
            stall    = (state_r == REQ) || (state_r == WAIT_R);
        end
    end

    // Access FSM with registered bus and result outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r  <= IDLE;
            cnt_r    <= 8'd0;
            funct3_r <= 3'd0;
            off_r    <= 2'd0;
            RDATA    <= 32'd0;
            done     <= 1'b0;
            bus_err  <= 1'b0;
            D_REQ    <= 1'b0;
            D_WE     <= 1'b0;
            D_ADDR   <= 32'd0;
            D_BE     <= 4'd0;
            D_WDATA  <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (acc_s && !illegal_s) begin
                        D_ADDR   <= {ADDR[31:2], 2'b00};
                        D_BE     <= BE << ADDR[1:0];
                        D_WDATA  <= WDATA << {ADDR[1:0], 3'b000};
                        D_WE     <= MemWrite;
                        funct3_r <= funct3;
                        off_r    <= ADDR[1:0];
                        cnt_r    <= 8'd0;
                        D_REQ    <= 1'b1;
                        state_r  <= REQ;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                REQ: begin
                    cnt_r <= cnt_r + 8'd1;
                    if (D_GNT) begin
                        D_REQ   <= 1'b0;
                        done    <= D_WE;
                        state_r <= D_WE ? RESP : WAIT_R;
                    end else if (tmo_s) begin
                        D_REQ   <= 1'b0;
                        bus_err <= 1'b1;
                        RDATA   <= 32'd0;
                        done    <= 1'b1;
                        state_r <= RESP;
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT_R: begin
                    cnt_r <= cnt_r + 8'd1;
                    if (D_RVALID) begin
                        RDATA   <= load_extract(D_RDATA, off_r, funct3_r);
                        done    <= 1'b1;
                        state_r <= RESP;
                    end else if (tmo_s) begin
                        bus_err <= 1'b1;
                        RDATA   <= 32'd0;
                        done    <= 1'b1;
                        state_r <= RESP;
                    end else begin
                        state_r <= WAIT_R;
                    end
                end
                RESP: begin
                    done    <= 1'b0;
                    bus_err <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    D_REQ   <= 1'b0;
                    done    <= 1'b0;
                    bus_err <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit: a bus responder with random
// grant/rvalid latency and a reference model of lane steering, extension and timeout.
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MemRead, MemWrite;
    logic [3:0]  BE;
    logic [2:0]  funct3;
    logic [31:0] ADDR, WDATA;
    logic [31:0] RDATA;
    logic        done, stall, misalign, bus_err;
    logic        D_REQ, D_WE;
    logic [31:0] D_ADDR;
    logic [3:0]  D_BE;
    logic [31:0] D_WDATA;
    logic        D_GNT, D_RVALID;
    logic [31:0] D_RDATA;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_rdata = 32'd0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .BE(BE),
        .funct3(funct3), .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA), .done(done),
        .stall(stall), .misalign(misalign), .bus_err(bus_err), .D_REQ(D_REQ),
        .D_WE(D_WE), .D_ADDR(D_ADDR), .D_BE(D_BE), .D_WDATA(D_WDATA),
        .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_illegal(input logic [3:0] be, input logic [1:0] off);
        bit ok;
        ok = (be == 4'b0001) || (be == 4'b0011 && off % 2 == 0) || (be == 4'b1111 && off == 2'd0);
        return !ok;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] w,
                                             input logic [1:0] off);
        logic [31:0] s;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        int v;
        s = w >> (8 * off);
        b = s[7:0];
        h = s[15:0];
        case (f3)
            3'd0:    v = int'(b);
            3'd1:    v = int'(h);
            3'd2:    v = int'(s);
            3'd4:    v = int'(s % 256);
            3'd5:    v = int'(s % 65536);
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    // gd: REQ cycles before grant; rd: extra WAIT_R cycles before rvalid
    task automatic access(input logic mr, input logic mw, input logic [3:0] be,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rword,
                          input int gd, input int rd);
        logic [1:0]  off;
        bit          bad, store, tmo, granted, fin;
        int          req_n, wc, cyc, req_exp;
        logic [31:0] be_exp, wd_exp;
        off     = addr[1:0];
        store   = mw;
        bad     = ref_illegal(be, off);
        be_exp  = (32'(be) << off) % 16;
        wd_exp  = wdata << (8 * off);
        granted = 1'b0;
        fin     = 1'b0;
        req_n   = 0;
        wc      = 0;
        cyc     = 0;
        @(negedge CLK);
        MemRead = mr; MemWrite = mw; BE = be; funct3 = f3; ADDR = addr; WDATA = wdata;
        #1;
        check("misalign", 32'(misalign), 32'(bad));
        check("stall_issue", 32'(stall), 32'(!bad));
        if (bad) begin
            @(negedge CLK);
            MemRead = 1'b0; MemWrite = 1'b0;
            #1;
            check("illegal_no_req", 32'(D_REQ), 32'd0);
            check("illegal_no_done", 32'(done), 32'd0);
            return;
        end
        if (gd > TO - 1) begin
            tmo = 1'b1; req_exp = TO;
        end else begin
            req_exp = gd + 1;
            tmo = !store && (gd + 1 + rd > TO - 1);
        end
        if (tmo) exp_rdata = 32'd0;
        else if (!store) exp_rdata = ref_load(f3, rword, off);
        while (!fin && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            D_GNT = 1'b0; D_RVALID = 1'b0; D_RDATA = $urandom;
            if (done) begin
                fin = 1'b1;
                MemRead = 1'b0; MemWrite = 1'b0;
            end else begin
                check("stall_busy", 32'(stall), 32'd1);
                if (D_REQ) begin
                    req_n++;
                    check("d_we", 32'(D_WE), 32'(store));
                    check("d_addr", D_ADDR, addr & 32'hFFFF_FFFC);
                    check("d_be", 32'(D_BE), be_exp);
                    check("d_wdata", D_WDATA, wd_exp);
                    if (req_n == gd + 1) begin
                        D_GNT = 1'b1; granted = 1'b1;
                    end else begin
                        D_RVALID = 1'($urandom_range(0, 1));
                    end
                end else if (granted) begin
                    wc++;
                    if (wc == rd + 1) begin
                        D_RVALID = 1'b1; D_RDATA = rword;
                    end
                end
            end
        end
        if (!fin) begin
            check("done_bound", 32'd0, 32'd1);
        end else begin
            check("req_cycles", 32'(req_n), 32'(req_exp));
            check("done_stall", 32'(stall), 32'd0);
            check("bus_err", 32'(bus_err), 32'(tmo));
            check("rdata", RDATA, exp_rdata);
        end
        @(negedge CLK);
        check("done_pulse", 32'(done), 32'd0);
        check("bus_err_clear", 32'(bus_err), 32'd0);
    endtask

    initial begin
        logic [31:0] a, w, r;
        logic [3:0]  be;
        logic [2:0]  f3;
        logic        mr, mw;
        int          op, sz, gd, rd;
        logic [2:0]  f3_tab [8];
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        RST = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; BE = 4'd0; funct3 = 3'd0;
        ADDR = 32'd0; WDATA = 32'd0; D_GNT = 1'b0; D_RVALID = 1'b0; D_RDATA = 32'd0;
        #12;
        check("rst_rdata", RDATA, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_d_req", 32'(D_REQ), 32'd0);
        check("rst_d_we", 32'(D_WE), 32'd0);
        check("rst_d_addr", D_ADDR, 32'd0);
        check("rst_d_be", 32'(D_BE), 32'd0);
        check("rst_d_wdata", D_WDATA, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        access(1'b0, 1'b1, 4'b1111, 3'd2, 32'h100, 32'hDEADBEEF, 32'd0, 2, 0);
        access(1'b1, 1'b0, 4'b0001, 3'd0, 32'h103, 32'd0, 32'h80FF0000, 0, 0);
        check("lb_value", RDATA, 32'hFFFFFF80);
        access(1'b1, 1'b0, 4'b0001, 3'd4, 32'h103, 32'd0, 32'h80FF0000, 1, 0);
        check("lbu_value", RDATA, 32'h00000080);
        access(1'b0, 1'b1, 4'b0011, 3'd1, 32'h202, 32'h0000ABCD, 32'd0, 0, 0);
        access(1'b1, 1'b0, 4'b0011, 3'd1, 32'h202, 32'd0, 32'h80011234, 0, 2);
        check("lh_value", RDATA, 32'hFFFF8001);
        access(1'b1, 1'b0, 4'b1111, 3'd2, 32'h101, 32'd0, 32'd0, 0, 0);

        // Reset while waiting for read data
        @(negedge CLK);
        MemRead = 1'b1; BE = 4'b1111; funct3 = 3'd2; ADDR = 32'h40;
        @(negedge CLK);
        D_GNT = 1'b1;
        @(negedge CLK);
        D_GNT = 1'b0;
        check("pre_rst_stall", 32'(stall), 32'd1);
        #2 RST = 1'b1; MemRead = 1'b0;
        #1;
        check("midrst_d_req", 32'(D_REQ), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        D_RVALID = 1'b1; D_RDATA = 32'h12345678;
        exp_rdata = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            D_RVALID = 1'b0;
            check("postrst_done", 32'(done), 32'd0);
            check("postrst_rdata", RDATA, 32'd0);
        end

        access(1'b1, 1'b0, 4'b1111, 3'd2, 32'h300, 32'd0, 32'hCAFEF00D, TO + 3, 0);
        access(1'b1, 1'b0, 4'b1111, 3'd2, 32'h304, 32'd0, 32'hCAFEF00D, 1, 1);

        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 9);
            a  = $urandom;
            w  = $urandom;
            r  = $urandom;
            mr = 1'b1; mw = 1'b0;
            f3 = f3_tab[$urandom_range(0, 7)];
            if (op < 2) begin
                be = 4'($urandom);
                mw = 1'($urandom_range(0, 1));
                mr = !mw || 1'($urandom_range(0, 1));
            end else if (op < 5) begin
                mw = 1'b1; mr = 1'($urandom_range(0, 1));
                sz = $urandom_range(0, 2);
                be = (sz == 0) ? 4'b0001 : (sz == 1) ? 4'b0011 : 4'b1111;
            end else begin
                case (f3 % 4)
                    3'd0:    be = 4'b0001;
                    3'd1:    be = 4'b0011;
                    3'd2:    be = 4'b1111;
                    default: be = 4'b0011;
                endcase
            end
            if (op >= 2) begin
                if (be == 4'b0011) a = a & 32'hFFFF_FFFE;
                if (be == 4'b1111) a = a & 32'hFFFF_FFFC;
            end
            gd = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 4);
            rd = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 16) : $urandom_range(0, 3);
            access(mr, mw, be, f3, a, w, r, gd, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
